// File: rtl/nco_sweep_scheduler.sv
// rtl/nco_sweep_scheduler.sv - frequency-sweep sequencer for the CORDIC NCO control word
module nco_sweep_scheduler #(
    parameter int SETTLE_CYCLES = 20,
    parameter int DWELL_W       = 16,
    parameter int IDX_W         = 10,
    parameter int MAX_WORD      = 46079
) (
    input  logic               clock,
    input  logic               resest,
    input  logic               start,
    input  logic               abort,
    input  logic [15:0]        cfg_start_word,
    input  logic [15:0]        cfg_stop_word,
    input  logic [15:0]        cfg_step_word,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_down,
    input  logic               cfg_loop,
    output logic [15:0]        freq_ctl_word,
    output logic               settled,
    output logic               step_strobe,
    output logic [IDX_W-1:0]   step_index,
    output logic               busy,
    output logic               done
);

    localparam int SETTLE_BITS = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_W       = (DWELL_W > SETTLE_BITS) ? DWELL_W : SETTLE_BITS;
    localparam logic [15:0]      MAX_W16     = 16'(MAX_WORD);
    localparam logic [16:0]      MAX_W17     = 17'(MAX_WORD);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DWELL  = 2'd2,
        STEP   = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [15:0]        start_q, stop_q, step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               down_q, loop_q;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [15:0]        word_nx;
    logic [IDX_W-1:0]   idx_nx;
    logic               strobe_nx, done_nx, latch_cfg;
    logic [CNT_W-1:0]   dwell_last;
    logic [16:0]        up_sum, dn_diff;
    logic               sweep_end;
    logic [15:0]        next_word;

    function automatic logic [15:0] clamp_word(input logic [15:0] w);
        return (w > MAX_W16) ? MAX_W16 : w;
    endfunction

    assign settled = (state == DWELL);
    assign busy    = (state != IDLE);

    // A zero dwell still holds the point for one cycle.
    assign dwell_last = (dwell_q == '0) ? '0 : CNT_W'(dwell_q) - CNT_W'(1);

    // 17-bit arithmetic so overflow past MAX_WORD and borrow below zero are both visible.
    assign up_sum    = {1'b0, freq_ctl_word} + {1'b0, step_q};
    assign dn_diff   = {1'b0, freq_ctl_word} - {1'b0, step_q};
    assign next_word = down_q ? dn_diff[15:0] : up_sum[15:0];
    assign sweep_end = (step_q == 16'd0)
                     || (!down_q && ((up_sum > {1'b0, stop_q}) || (up_sum > MAX_W17)))
                     || ( down_q && (dn_diff[16] || (dn_diff[15:0] < stop_q)));

    always_comb begin
        state_nx  = state;
        word_nx   = freq_ctl_word;
        idx_nx    = step_index;
        cnt_nx    = cnt;
        strobe_nx = 1'b0;
        done_nx   = 1'b0;
        latch_cfg = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    latch_cfg = 1'b1;
                    word_nx   = clamp_word(cfg_start_word);
                    idx_nx    = '0;
                    cnt_nx    = '0;
                    strobe_nx = 1'b1;
                    state_nx  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_nx   = '0;
                    state_nx = DWELL;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DWELL: begin
                if (cnt == dwell_last) begin
                    cnt_nx   = '0;
                    state_nx = STEP;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            STEP: begin
                cnt_nx = '0;
                if (!sweep_end) begin
                    word_nx   = next_word;
                    idx_nx    = step_index + IDX_W'(1);
                    strobe_nx = 1'b1;
                    state_nx  = SETTLE;
                end else if (loop_q) begin
                    word_nx   = start_q;
                    idx_nx    = '0;
                    strobe_nx = 1'b1;
                    state_nx  = SETTLE;
                end else begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Abort wins over every transition and leaves the word where it was.
        if (abort && (state != IDLE)) begin
            state_nx  = IDLE;
            word_nx   = freq_ctl_word;
            idx_nx    = step_index;
            cnt_nx    = '0;
            strobe_nx = 1'b0;
            done_nx   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (resest) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clock) begin
        if (resest) begin
            freq_ctl_word <= '0;
            step_index    <= '0;
            cnt           <= '0;
            step_strobe   <= 1'b0;
            done          <= 1'b0;
            start_q       <= '0;
            stop_q        <= '0;
            step_q        <= '0;
            dwell_q       <= '0;
            down_q        <= 1'b0;
            loop_q        <= 1'b0;
        end else begin
            freq_ctl_word <= word_nx;
            step_index    <= idx_nx;
            cnt           <= cnt_nx;
            step_strobe   <= strobe_nx;
            done          <= done_nx;
            if (latch_cfg) begin
                start_q <= clamp_word(cfg_start_word);
                stop_q  <= clamp_word(cfg_stop_word);
                step_q  <= clamp_word(cfg_step_word);
                dwell_q <= cfg_dwell;
                down_q  <= cfg_down;
                loop_q  <= cfg_loop;
            end
        end
    end

endmodule

// File: tb/tb_nco_sweep_scheduler.sv
// tb/tb_nco_sweep_scheduler.sv - directed scoreboard bench for nco_sweep_scheduler
module tb_nco_sweep_scheduler;

    logic        clock = 1'b0;
    logic        resest, start, abort, cfg_down, cfg_loop;
    logic [15:0] cfg_start_word, cfg_stop_word, cfg_step_word, cfg_dwell;
    logic [15:0] freq_ctl_word;
    logic [9:0]  step_index;
    logic        settled, step_strobe, busy, done;

    nco_sweep_scheduler dut (
        .clock(clock), .resest(resest), .start(start), .abort(abort),
        .cfg_start_word(cfg_start_word), .cfg_stop_word(cfg_stop_word),
        .cfg_step_word(cfg_step_word), .cfg_dwell(cfg_dwell),
        .cfg_down(cfg_down), .cfg_loop(cfg_loop),
        .freq_ctl_word(freq_ctl_word), .settled(settled), .step_strobe(step_strobe),
        .step_index(step_index), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] word;
        logic [9:0]  idx;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc, last_strobe, run_len, exp_dwell, n_done, n_settled;
    logic [15:0] cur_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic begin_test(input int dwell);
        sb.delete();
        exp_dwell   = dwell;
        last_strobe = -1000;
        run_len     = 0;
        n_done      = 0;
        n_settled   = 0;
        cyc         = 0;
    endtask

    task automatic push(input logic [15:0] w, input logic [9:0] i);
        exp_t e;
        e.word = w;
        e.idx  = i;
        sb.push_back(e);
    endtask

    // Samples at the current negedge, then advances one cycle, ncyc times.
    task automatic mon(input int ncyc);
        exp_t e;
        for (int c = 0; c < ncyc; c++) begin
            if (step_strobe) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", step_strobe, 0);
                end else begin
                    e = sb.pop_front();
                    check("strobe_word", freq_ctl_word, e.word);
                    check("strobe_index", step_index, e.idx);
                    cur_word = e.word;
                end
                last_strobe = cyc;
            end
            if (settled) begin
                if (run_len == 0) check("settle_latency", cyc - last_strobe, 20);
                check("dwell_word", freq_ctl_word, cur_word);
                run_len++;
                n_settled++;
            end else if (run_len != 0) begin
                check("dwell_len", run_len, exp_dwell);
                run_len = 0;
            end
            if (done) begin
                n_done++;
                check("done_busy", busy, 0);
                check("done_no_strobe", step_strobe, 0);
                check("done_timing", cyc - last_strobe, 21 + exp_dwell);
            end
            cyc++;
            @(negedge clock);
        end
    endtask

    task automatic set_cfg(input int sw, input int pw, input int st, input int dw,
                           input logic dn, input logic lp);
        cfg_start_word = 16'(sw);
        cfg_stop_word  = 16'(pw);
        cfg_step_word  = 16'(st);
        cfg_dwell      = 16'(dw);
        cfg_down       = dn;
        cfg_loop       = lp;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_word"}, freq_ctl_word, 0);
        check({tag, "_index"}, step_index, 0);
        check({tag, "_settled"}, settled, 0);
        check({tag, "_strobe"}, step_strobe, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        resest = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        cur_word = '0;
        set_cfg(0, 0, 0, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        check_zero("reset");
        resest = 1'b0;

        // Reset asserted mid-sweep
        set_cfg(100, 400, 100, 5, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (30) @(negedge clock);
        check("pre_reset_busy", busy, 1);
        resest = 1'b1;
        repeat (3) @(negedge clock);
        check_zero("midreset");
        resest = 1'b0;
        @(negedge clock);

        // Up sweep
        begin_test(5);
        push(100, 0); push(200, 1); push(300, 2); push(400, 3);
        start = 1'b1;
        mon(1);
        start = 1'b0;
        set_cfg(7, 7, 7, 7, 1'b1, 1'b1);
        check("first_strobe", step_strobe, 1);
        mon(115);
        check("up_done_count", n_done, 1);
        check("up_settled_cycles", n_settled, 20);
        check("up_queue_empty", sb.size(), 0);
        check("up_final_word", freq_ctl_word, 400);
        check("up_idle", busy, 0);

        // Down sweep ending on borrow, zero dwell
        begin_test(1);
        set_cfg(1000, 0, 300, 0, 1'b1, 1'b0);
        push(1000, 0); push(700, 1); push(400, 2); push(100, 3);
        start = 1'b1;
        mon(1);
        start = 1'b0;
        mon(100);
        check("dn_done_count", n_done, 1);
        check("dn_settled_cycles", n_settled, 4);
        check("dn_queue_empty", sb.size(), 0);
        check("dn_final_word", freq_ctl_word, 100);

        // Looping sweep, then abort during SETTLE
        begin_test(2);
        set_cfg(0, 46079, 40000, 2, 1'b0, 1'b1);
        push(0, 0); push(40000, 1); push(0, 0); push(40000, 1);
        start = 1'b1;
        mon(1);
        start = 1'b0;
        mon(71);
        check("loop_done_count", n_done, 0);
        check("loop_settled_cycles", n_settled, 6);
        check("loop_queue_empty", sb.size(), 0);
        check("loop_in_settle", busy & ~settled, 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_word", freq_ctl_word, 40000);
        check("abort_settled", settled, 0);
        check("abort_done", done, 0);
        n_settled = 0;
        mon(30);
        check("abort_no_settle", n_settled, 0);
        check("abort_no_done", n_done, 0);

        // Clamped start word, single point, start while busy ignored
        begin_test(30);
        set_cfg(50000, 0, 0, 30, 1'b0, 1'b0);
        push(46079, 0);
        start = 1'b1;
        mon(1);
        start = 1'b0;
        mon(5);
        set_cfg(123, 500, 10, 3, 1'b0, 1'b1);
        start = 1'b1;
        mon(1);
        start = 1'b0;
        mon(60);
        check("clamp_done_count", n_done, 1);
        check("clamp_settled_cycles", n_settled, 30);
        check("clamp_queue_empty", sb.size(), 0);
        check("clamp_final_word", freq_ctl_word, 46079);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
